data_mem_responder: RTL and testbench



---
 rtl/data_mem_responder_pkg.sv | 29 ++
 rtl/data_mem_responder_if.sv | 28 ++
 rtl/data_mem_responder_wait_ctr.sv | 39 +++
 rtl/data_mem_responder.sv | 138 +++++++++++++
 tb/tb_data_mem_responder.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/data_mem_responder_pkg.sv
// Shared types and constants for the wait-state data-memory responder.
// Build option: DM_MISALIGN_TRAP_EN (see data_mem_responder.sv).
package dm_pkg;

    localparam int WORD_W = 32;
    localparam int CTR_W  = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2,
        DONE = 2'd3
    } dm_state_e;

    typedef enum logic {
        OP_RD = 1'b0,
        OP_WR = 1'b1
    } dm_op_e;

    function automatic int dm_clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// CPU data-bus link between the requester (master) and the memory responder (slave).
interface data_mem_responder_if;
    import dm_pkg::*;

    // Handshake: the master raises mRD or mWR and holds it, with address and
    // DataIn stable, until mReady; mReady is a single-cycle strobe, mErr and
    // DMOut are meaningful in that cycle. The master must drop both requests
    // before the slave will accept another access.
    logic              mRD;
    logic              mWR;
    logic [WORD_W-1:0] address;
    logic [WORD_W-1:0] DataIn;
    logic [WORD_W-1:0] DMOut;
    logic              mReady;
    logic              mErr;
    logic              busy;

    modport master (
        output mRD, mWR, address, DataIn,
        input  DMOut, mReady, mErr, busy
    );

    modport slave (
        input  mRD, mWR, address, DataIn,
        output DMOut, mReady, mErr, busy
    );

endinterface

// File: rtl/data_mem_responder_wait_ctr.sv
// Loadable down-counter that sets the wait-state length; flags terminal count zero.
module dm_wait_ctr
    import dm_pkg::*;
#(
    parameter int W = CTR_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic [W-1:0] count,
    output logic         is_zero
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign count   = cnt_q;
    assign is_zero = (cnt_q == '0);

endmodule

// File: rtl/data_mem_responder.sv
// Registered, handshaked data memory with WAIT_CYCLES wait states and error flagging.
// Define DM_MISALIGN_TRAP_EN to reject addresses with address[1:0] != 0.
module data_mem_responder
    import dm_pkg::*;
#(
    parameter int DEPTH_WORDS = 64,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                 CLK,
    input  logic                 RST,
    data_mem_responder_if.slave  bus,
    output dm_state_e            dbg_state
);

    localparam int AW = dm_clog2(DEPTH_WORDS);
    localparam logic [CTR_W-1:0] WAIT_LD = CTR_W'(WAIT_CYCLES);

    dm_state_e         state_q, state_d;
    dm_op_e            op_q, op_d;
    logic [AW-1:0]     idx_q, idx_d;
    logic [WORD_W-1:0] wdata_q, wdata_d;
    logic              err_q, err_d;
    logic [WORD_W-1:0] dmout_q, dmout_d;

    logic [WORD_W-1:0] mem_q [DEPTH_WORDS];

    logic              req;
    logic              accept;
    logic              commit;
    logic              ctr_zero;
    logic [CTR_W-1:0]  ctr_count;
    logic              req_both;
    logic              out_of_range;
    logic              misaligned;
    logic              acc_err;
    logic              mem_we;

    assign req    = bus.mRD | bus.mWR;
    assign accept = (state_q == IDLE) && req;
    // The access takes effect on the edge that moves WAIT -> RESP.
    assign commit = (state_q == WAIT) && ctr_zero;
    assign mem_we = commit && !err_q && (op_q == OP_WR);

    assign req_both     = bus.mRD & bus.mWR;
    assign out_of_range = |(bus.address >> (AW + 2));
`ifdef DM_MISALIGN_TRAP_EN
    assign misaligned   = |bus.address[1:0];
`else
    assign misaligned   = 1'b0;
`endif
    assign acc_err = req_both | out_of_range | misaligned;

    dm_wait_ctr #(
        .W (CTR_W)
    ) u_wait_ctr (
        .clk      (CLK),
        .rst      (RST),
        .load     (accept),
        .load_val (WAIT_LD),
        .dec      (state_q == WAIT),
        .count    (ctr_count),
        .is_zero  (ctr_zero)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // WAIT always runs WAIT_CYCLES+1 cycles (counter drains to zero), so the
    // response strobe follows edge WAIT_CYCLES+1 after acceptance, also for 0.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (req) state_d = WAIT;
            WAIT:    if (ctr_zero) state_d = RESP;
            RESP:    state_d = DONE;
            DONE:    if (!req) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.mReady = (state_q == RESP);
        bus.mErr   = (state_q == RESP) && err_q;
        bus.busy   = (state_q != IDLE);
        bus.DMOut  = dmout_q;
        dbg_state  = state_q;
    end

    always_comb begin
        op_d    = op_q;
        idx_d   = idx_q;
        wdata_d = wdata_q;
        err_d   = err_q;
        dmout_d = dmout_q;
        if (accept) begin
            op_d    = bus.mWR ? OP_WR : OP_RD;
            idx_d   = bus.address[AW+1:2];
            wdata_d = bus.DataIn;
            err_d   = acc_err;
        end
        if (commit && !err_q && (op_q == OP_RD)) begin
            dmout_d = mem_q[idx_q];
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            op_q    <= OP_RD;
            idx_q   <= '0;
            wdata_q <= '0;
            err_q   <= 1'b0;
            dmout_q <= '0;
        end else begin
            op_q    <= op_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            err_q   <= err_d;
            dmout_q <= dmout_d;
        end
    end

    // Storage survives reset; an aborted write never reaches here because
    // reset forces the FSM out of WAIT before the commit edge.
    always_ff @(posedge CLK) begin
        if (mem_we) begin
            mem_q[idx_q] <= wdata_q;
        end
    end

    logic unused_ok;
    assign unused_ok = ^ctr_count;

endmodule

// File: tb/tb_data_mem_responder.sv
// Randomized bench for data_mem_responder: two instances (2 and 0 wait states) vs a word-array model.
module tb_data_mem_responder;
  import dm_pkg::*;

  localparam int DEPTH = 64;
  localparam int AW    = $clog2(DEPTH);

  logic clk;
  logic rst;
  dm_state_e st0, st1;

  data_mem_responder_if bus0 ();
  data_mem_responder_if bus1 ();

  data_mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(2)) dut_w2 (
    .CLK(clk), .RST(rst), .bus(bus0), .dbg_state(st0)
  );
  data_mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0)) dut_w0 (
    .CLK(clk), .RST(rst), .bus(bus1), .dbg_state(st1)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp;
  int n_bad;
  logic [31:0] model_mem [2][DEPTH];
  logic [31:0] model_dout [2];
  logic [31:0] exp_q [$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int exp_lat(input int sel);
    return (sel == 0) ? 3 : 1;
  endfunction

  task automatic drive(input int sel, input bit rd, input bit wr,
                       input logic [31:0] addr, input logic [31:0] data);
    if (sel == 0) begin
      bus0.mRD = rd; bus0.mWR = wr; bus0.address = addr; bus0.DataIn = data;
    end else begin
      bus1.mRD = rd; bus1.mWR = wr; bus1.address = addr; bus1.DataIn = data;
    end
  endtask

  function automatic logic get_rdy(input int sel);
    return (sel == 0) ? bus0.mReady : bus1.mReady;
  endfunction
  function automatic logic get_err(input int sel);
    return (sel == 0) ? bus0.mErr : bus1.mErr;
  endfunction
  function automatic logic get_busy(input int sel);
    return (sel == 0) ? bus0.busy : bus1.busy;
  endfunction
  function automatic logic [31:0] get_dout(input int sel);
    return (sel == 0) ? bus0.DMOut : bus1.DMOut;
  endfunction

  // One complete transaction; the model decides the outcome before the DUT runs.
  task automatic access(input int sel, input bit rd, input bit wr,
                        input logic [31:0] addr, input logic [31:0] data, input int hold);
    bit          exp_err;
    int          idx;
    int          edge_n;
    int          lat;
    int          pulses;
    bit          seen;
    logic        got_err;
    logic [31:0] got_dout;

    idx = int'(addr[AW+1:2]);
    exp_err = (rd && wr) || ((addr >> (AW + 2)) != 0);
`ifdef DM_MISALIGN_TRAP_EN
    if (addr[1:0] != 2'b00) exp_err = 1'b1;
`endif
    if (!exp_err && wr) model_mem[sel][idx] = data;
    if (!exp_err && rd) model_dout[sel] = model_mem[sel][idx];
    exp_q.push_back(model_dout[sel]);

    @(negedge clk);
    drive(sel, rd, wr, addr, data);
    seen = 0; lat = -1; pulses = 0; edge_n = 0;
    got_err = 1'b0; got_dout = '0;
    while (!seen && edge_n < 40) begin
      @(posedge clk); #1;
      if (edge_n == 0) chk("busy_in_wait", 32'(get_busy(sel)), 32'd1);
      if (get_rdy(sel)) begin
        seen = 1; lat = edge_n; pulses++;
        got_err = get_err(sel); got_dout = get_dout(sel);
      end
      edge_n++;
    end
    if (!seen) chk("ready_timeout", 32'd0, 32'd1);
    chk("latency", 32'(lat), 32'(exp_lat(sel)));
    chk("merr", 32'(got_err), 32'(exp_err));
    chk("dmout", got_dout, exp_q.pop_front());
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      if (get_rdy(sel)) pulses++;
    end
    @(negedge clk);
    drive(sel, 1'b0, 1'b0, '0, '0);
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      if (get_rdy(sel)) pulses++;
    end
    chk("single_pulse", 32'(pulses), 32'd1);
    chk("busy_after", 32'(get_busy(sel)), 32'd0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_busy0"}, 32'(bus0.busy), 32'd0);
    chk({tag, "_rdy0"}, 32'(bus0.mReady), 32'd0);
    chk({tag, "_err0"}, 32'(bus0.mErr), 32'd0);
    chk({tag, "_dout0"}, bus0.DMOut, 32'd0);
    chk({tag, "_state0"}, 32'(st0), 32'(IDLE));
    chk({tag, "_busy1"}, 32'(bus1.busy), 32'd0);
    chk({tag, "_dout1"}, bus1.DMOut, 32'd0);
    chk({tag, "_state1"}, 32'(st1), 32'(IDLE));
  endtask

  initial begin
    bit          rd, wr;
    int          r, sel, hold;
    logic [31:0] addr, data;

    n_cmp = 0; n_bad = 0;
    rst = 1'b0;
    drive(0, 1'b0, 1'b0, '0, '0);
    drive(1, 1'b0, 1'b0, '0, '0);
    model_dout[0] = '0; model_dout[1] = '0;

    // asynchronous reset mid-cycle, before any clock edge
    #3 rst = 1'b1;
    #1 chk_reset_outputs("reset");
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // fill both memories so the model knows every word
    for (int s = 0; s < 2; s++) begin
      for (int w = 0; w < DEPTH; w++) begin
        access(s, 1'b0, 1'b1, 32'(w) << 2, $urandom, 0);
      end
    end

    // write then read back, requester holding the read 3 extra cycles
    access(0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 0);
    access(0, 1'b1, 1'b0, 32'h10, 32'h0, 3);
    chk("rd_deadbeef", model_dout[0], 32'hDEADBEEF);

    // both strobes high is an error; contents untouched
    access(0, 1'b1, 1'b1, 32'h08, 32'hFFFF0000, 0);
    access(0, 1'b1, 1'b0, 32'h08, 32'h0, 0);

    // range boundary
    access(0, 1'b1, 1'b0, 32'h400, 32'h0, 0);
    access(0, 1'b1, 1'b0, 32'h0FC, 32'h0, 0);

    // reset during WAIT aborts the write
    @(negedge clk);
    drive(0, 1'b0, 1'b1, 32'h20, 32'h12345678);
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    model_dout[0] = '0; model_dout[1] = '0;
    #1 chk_reset_outputs("abort");
    @(negedge clk);
    drive(0, 1'b0, 1'b0, '0, '0);
    rst = 1'b0;
    access(0, 1'b1, 1'b0, 32'h20, 32'h0, 1);

    // zero wait states, misaligned read
    access(1, 1'b1, 1'b0, 32'h06, 32'h0, 0);
    access(1, 1'b1, 1'b0, 32'h04, 32'h0, 0);

    // randomized traffic, including back-to-back write/read of one word
    for (int k = 0; k < 80; k++) begin
      sel  = ($urandom_range(0, 3) == 0) ? 1 : 0;
      r    = $urandom_range(0, 9);
      rd   = (r == 0) || (r < 5);
      wr   = (r == 0) || (r >= 5);
      addr = 32'($urandom_range(0, DEPTH - 1)) << 2;
      if ($urandom_range(0, 7) == 0) addr = addr | (32'd1 << $urandom_range(AW + 2, 31));
      if ($urandom_range(0, 7) == 0) addr[1:0] = 2'($urandom_range(1, 3));
      data = $urandom;
      hold = $urandom_range(0, 3);
      access(sel, rd, wr, addr, data, hold);
      if (wr && !rd && $urandom_range(0, 2) == 0) access(sel, 1'b1, 1'b0, addr, 32'h0, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
